// File: rtl/gmem_m_axi_pkg.sv
// Shared helpers for the gmem AXI write path: ceil-log2 and counter-width sizing.
package gmem_m_axi_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a counter that must hold 0..n inclusive without wrapping.
  function automatic int cnt_width(input int n);
    return clog2(n) + 1;
  endfunction

endpackage

// File: rtl/gmem_m_axi_sfifo.sv
// Synchronous FIFO, flop-based storage, head entry read from registers; latency 1 cycle push->not-empty.
// A push at full is taken only when a pop frees an entry in the same cycle; a pop when empty is ignored.
module gmem_m_axi_sfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  import gmem_m_axi_pkg::*;

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = en && pop && !empty;
  assign do_push = en && push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/gmem_m_axi_wthrottle.sv
// AXI write throttle: a bus AW is issued only once its whole burst (through WLAST) is buffered. Latency 1 cycle.
// Upstream ready = FIFO not-full; bus AW also held off at MAX_OUTSTANDING. Option GMEM_WTHROTTLE_STATS_EN adds stat_aw_stall.
module gmem_m_axi_wthrottle
  import gmem_m_axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int DEPTH           = 16,
  parameter int MAXREQS         = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clk_en,
  input  logic [ADDR_WIDTH-1:0]   in_TOP_AWADDR,
  input  logic [LEN_WIDTH-1:0]    in_TOP_AWLEN,
  input  logic                    in_TOP_AWVALID,
  output logic                    out_TOP_AWREADY,
  input  logic [DATA_WIDTH-1:0]   in_TOP_WDATA,
  input  logic [DATA_WIDTH/8-1:0] in_TOP_WSTRB,
  input  logic                    in_TOP_WLAST,
  input  logic                    in_TOP_WVALID,
  output logic                    out_TOP_WREADY,
  output logic                    out_TOP_BVALID,
  input  logic                    in_TOP_BREADY,
  output logic [ADDR_WIDTH-1:0]   out_BUS_AWADDR,
  output logic [LEN_WIDTH-1:0]    out_BUS_AWLEN,
  output logic                    out_BUS_AWVALID,
  input  logic                    in_BUS_AWREADY,
  output logic [DATA_WIDTH-1:0]   out_BUS_WDATA,
  output logic [DATA_WIDTH/8-1:0] out_BUS_WSTRB,
  output logic                    out_BUS_WLAST,
  output logic                    out_BUS_WVALID,
  input  logic                    in_BUS_WREADY,
  input  logic                    in_BUS_BVALID,
  output logic                    out_BUS_BREADY
`ifdef GMEM_WTHROTTLE_STATS_EN
  ,
  output logic [31:0]             stat_aw_stall
`endif
);

  localparam int SW   = DATA_WIDTH / 8;
  localparam int AWW  = ADDR_WIDTH + LEN_WIDTH;
  localparam int WW   = 1 + SW + DATA_WIDTH;
  localparam int LCW  = cnt_width(DEPTH);
  localparam int OCW  = cnt_width(MAX_OUTSTANDING);
  localparam int CMPW = (LCW > OCW) ? LCW : OCW;

  logic           req_full, req_empty, dat_full, dat_empty;
  logic [AWW-1:0] req_dout;
  logic [WW-1:0]  dat_dout;
  logic [LCW-1:0] last_cnt;
  logic [OCW-1:0] aw_credit;
  logic [OCW-1:0] outstanding;
  logic           aw_push, w_push, aw_hs, w_hs, b_hs;
  logic           last_push, last_pop, b_dec;

  assign out_TOP_AWREADY = !req_full;
  assign out_TOP_WREADY  = !dat_full;
  assign out_TOP_BVALID  = in_BUS_BVALID;
  assign out_BUS_BREADY  = in_TOP_BREADY;

  assign aw_push   = clk_en && in_TOP_AWVALID && out_TOP_AWREADY;
  assign w_push    = clk_en && in_TOP_WVALID && out_TOP_WREADY;
  assign aw_hs     = clk_en && out_BUS_AWVALID && in_BUS_AWREADY;
  assign w_hs      = clk_en && out_BUS_WVALID && in_BUS_WREADY;
  assign b_hs      = clk_en && in_BUS_BVALID && in_TOP_BREADY;
  assign last_push = w_push && in_TOP_WLAST;
  assign last_pop  = w_hs && out_BUS_WLAST;
  assign b_dec     = b_hs && (outstanding != '0);

  // last_cnt - aw_credit never shrinks without an AW handshake, so AWVALID holds until accepted.
  assign out_BUS_AWVALID = !req_empty
                        && (CMPW'(last_cnt) > CMPW'(aw_credit))
                        && (outstanding < OCW'(MAX_OUTSTANDING));
  assign out_BUS_WVALID  = !dat_empty && (aw_credit != '0);

  assign {out_BUS_AWADDR, out_BUS_AWLEN}               = req_dout;
  assign {out_BUS_WLAST, out_BUS_WSTRB, out_BUS_WDATA} = dat_dout;

  gmem_m_axi_sfifo #(.WIDTH(AWW), .DEPTH(MAXREQS)) u_req_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (clk_en),
    .push  (aw_push),
    .din   ({in_TOP_AWADDR, in_TOP_AWLEN}),
    .full  (req_full),
    .pop   (aw_hs),
    .dout  (req_dout),
    .empty (req_empty)
  );

  gmem_m_axi_sfifo #(.WIDTH(WW), .DEPTH(DEPTH)) u_dat_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .en    (clk_en),
    .push  (w_push),
    .din   ({in_TOP_WLAST, in_TOP_WSTRB, in_TOP_WDATA}),
    .full  (dat_full),
    .pop   (w_hs),
    .dout  (dat_dout),
    .empty (dat_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_cnt    <= '0;
      aw_credit   <= '0;
      outstanding <= '0;
    end else if (clk_en) begin
      last_cnt    <= last_cnt + LCW'(last_push) - LCW'(last_pop);
      aw_credit   <= aw_credit + OCW'(aw_hs) - OCW'(last_pop);
      outstanding <= outstanding + OCW'(aw_hs) - OCW'(b_dec);
    end
  end

`ifdef GMEM_WTHROTTLE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_aw_stall <= '0;
    end else if (clk_en && !req_empty && !out_BUS_AWVALID && (stat_aw_stall != '1)) begin
      stat_aw_stall <= stat_aw_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gmem_m_axi_wthrottle.sv
// Bench for gmem_m_axi_wthrottle: queue-based reference model, directed scenarios, then randomized traffic.
module tb_gmem_m_axi_wthrottle;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 8;
  localparam int SW   = DW / 8;
  localparam int DEP  = 4;
  localparam int MREQ = 4;
  localparam int MOUT = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } aw_t;

  typedef struct packed {
    logic          last;
    logic [SW-1:0] strb;
    logic [DW-1:0] data;
  } w_t;

  logic          clk = 1'b0;
  logic          reset_n, clk_en;
  logic [AW-1:0] in_TOP_AWADDR;
  logic [LW-1:0] in_TOP_AWLEN;
  logic          in_TOP_AWVALID, out_TOP_AWREADY;
  logic [DW-1:0] in_TOP_WDATA;
  logic [SW-1:0] in_TOP_WSTRB;
  logic          in_TOP_WLAST, in_TOP_WVALID, out_TOP_WREADY;
  logic          out_TOP_BVALID, in_TOP_BREADY;
  logic [AW-1:0] out_BUS_AWADDR;
  logic [LW-1:0] out_BUS_AWLEN;
  logic          out_BUS_AWVALID, in_BUS_AWREADY;
  logic [DW-1:0] out_BUS_WDATA;
  logic [SW-1:0] out_BUS_WSTRB;
  logic          out_BUS_WLAST, out_BUS_WVALID, in_BUS_WREADY;
  logic          in_BUS_BVALID, out_BUS_BREADY;
`ifdef GMEM_WTHROTTLE_STATS_EN
  logic [31:0]   stat_aw_stall;
`endif

  gmem_m_axi_wthrottle #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .DEPTH(DEP), .MAXREQS(MREQ), .MAX_OUTSTANDING(MOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en),
    .in_TOP_AWADDR(in_TOP_AWADDR), .in_TOP_AWLEN(in_TOP_AWLEN),
    .in_TOP_AWVALID(in_TOP_AWVALID), .out_TOP_AWREADY(out_TOP_AWREADY),
    .in_TOP_WDATA(in_TOP_WDATA), .in_TOP_WSTRB(in_TOP_WSTRB), .in_TOP_WLAST(in_TOP_WLAST),
    .in_TOP_WVALID(in_TOP_WVALID), .out_TOP_WREADY(out_TOP_WREADY),
    .out_TOP_BVALID(out_TOP_BVALID), .in_TOP_BREADY(in_TOP_BREADY),
    .out_BUS_AWADDR(out_BUS_AWADDR), .out_BUS_AWLEN(out_BUS_AWLEN),
    .out_BUS_AWVALID(out_BUS_AWVALID), .in_BUS_AWREADY(in_BUS_AWREADY),
    .out_BUS_WDATA(out_BUS_WDATA), .out_BUS_WSTRB(out_BUS_WSTRB), .out_BUS_WLAST(out_BUS_WLAST),
    .out_BUS_WVALID(out_BUS_WVALID), .in_BUS_WREADY(in_BUS_WREADY),
    .in_BUS_BVALID(in_BUS_BVALID), .out_BUS_BREADY(out_BUS_BREADY)
`ifdef GMEM_WTHROTTLE_STATS_EN
    , .stat_aw_stall(stat_aw_stall)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus sources and reference model state
  aw_t aw_src[$];
  w_t  w_src[$];
  aw_t req_q[$];
  w_t  dat_q[$];
  int  pend_w, outst, b_owed;
  int  n_vec, n_bad;
  int  dut_aw_hs, dut_w_hs, dut_up_w;
  int  b_mode;     // 0 withhold B, 1 B whenever owed, 2 random, 3 one B then withhold
  int  p_aw = 100;
  int  p_w  = 100;
  bit  rnd_mode;
  logic obs_awvalid, obs_wvalid, obs_wready;
  int  obs_last_cnt;
  longint exp_stall;
  longint obs_stat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lasts_in_fifo();
    int n;
    n = 0;
    foreach (dat_q[i]) if (dat_q[i].last) n++;
    return n;
  endfunction

  // One clock: check outputs at negedge against the model, advance the model, drive next inputs after posedge.
  task automatic step();
    logic e_awrdy, e_wrdy, e_awvld, e_wvld;
    logic aw_up, w_up, aw_bus, w_bus, b_hs;
    aw_t a;
    w_t  w;
    @(negedge clk);
    e_awrdy = (req_q.size() < MREQ);
    e_wrdy  = (dat_q.size() < DEP);
    e_awvld = (req_q.size() > 0) && (lasts_in_fifo() > pend_w) && (outst < MOUT);
    e_wvld  = (dat_q.size() > 0) && (pend_w > 0);
    chk("top_awready", out_TOP_AWREADY, e_awrdy);
    chk("top_wready", out_TOP_WREADY, e_wrdy);
    chk("bus_awvalid", out_BUS_AWVALID, e_awvld);
    chk("bus_wvalid", out_BUS_WVALID, e_wvld);
    if (e_awvld) begin
      chk("bus_awaddr", out_BUS_AWADDR, req_q[0].addr);
      chk("bus_awlen", out_BUS_AWLEN, req_q[0].len);
    end
    if (e_wvld) begin
      chk("bus_wdata", out_BUS_WDATA, dat_q[0].data);
      chk("bus_wstrb", out_BUS_WSTRB, dat_q[0].strb);
      chk("bus_wlast", out_BUS_WLAST, dat_q[0].last);
    end
    chk("top_bvalid", out_TOP_BVALID, in_BUS_BVALID);
    chk("bus_bready", out_BUS_BREADY, in_TOP_BREADY);
    chk("last_cnt", dut.last_cnt, lasts_in_fifo());
`ifdef GMEM_WTHROTTLE_STATS_EN
    chk("stat_aw_stall", stat_aw_stall, exp_stall);
    obs_stat = stat_aw_stall;
`endif
    obs_awvalid  = out_BUS_AWVALID;
    obs_wvalid   = out_BUS_WVALID;
    obs_wready   = out_TOP_WREADY;
    obs_last_cnt = int'(dut.last_cnt);
    if (clk_en && out_BUS_AWVALID && in_BUS_AWREADY) dut_aw_hs++;
    if (clk_en && out_BUS_WVALID && in_BUS_WREADY) dut_w_hs++;
    if (clk_en && in_TOP_WVALID && out_TOP_WREADY) dut_up_w++;

    aw_up  = clk_en && in_TOP_AWVALID && e_awrdy;
    w_up   = clk_en && in_TOP_WVALID && e_wrdy;
    aw_bus = clk_en && e_awvld && in_BUS_AWREADY;
    w_bus  = clk_en && e_wvld && in_BUS_WREADY;
    b_hs   = clk_en && in_BUS_BVALID && in_TOP_BREADY;
    if (clk_en && (req_q.size() > 0) && !e_awvld && (exp_stall < 64'hFFFF_FFFF)) exp_stall++;
    if (w_bus) begin
      w = dat_q.pop_front();
      if (w.last) begin
        pend_w--;
        b_owed++;
      end
    end
    if (aw_bus) begin
      a = req_q.pop_front();
      pend_w++;
      outst++;
    end
    if (b_hs) begin
      if (outst > 0) outst--;
      b_owed--;
    end
    if (aw_up) req_q.push_back({in_TOP_AWADDR, in_TOP_AWLEN});
    if (w_up) dat_q.push_back({in_TOP_WLAST, in_TOP_WSTRB, in_TOP_WDATA});

    @(posedge clk);
    #1;
    if (!(in_TOP_AWVALID && !aw_up)) begin
      in_TOP_AWVALID = 1'b0;
      if (aw_src.size() > 0 && $urandom_range(99) < p_aw) begin
        a = aw_src.pop_front();
        in_TOP_AWADDR  = a.addr;
        in_TOP_AWLEN   = a.len;
        in_TOP_AWVALID = 1'b1;
      end
    end
    if (!(in_TOP_WVALID && !w_up)) begin
      in_TOP_WVALID = 1'b0;
      if (w_src.size() > 0 && $urandom_range(99) < p_w) begin
        w = w_src.pop_front();
        in_TOP_WDATA  = w.data;
        in_TOP_WSTRB  = w.strb;
        in_TOP_WLAST  = w.last;
        in_TOP_WVALID = 1'b1;
      end
    end
    if (b_mode == 3 && b_hs) b_mode = 0;
    case (b_mode)
      0:       in_BUS_BVALID = 1'b0;
      1, 3:    in_BUS_BVALID = (b_owed > 0);
      default: if (!(in_BUS_BVALID && !b_hs)) in_BUS_BVALID = (b_owed > 0) && ($urandom_range(1) == 1);
    endcase
    if (rnd_mode) begin
      in_BUS_AWREADY = ($urandom_range(1) == 1);
      in_BUS_WREADY  = ($urandom_range(3) != 0);
      in_TOP_BREADY  = ($urandom_range(3) != 0);
      clk_en         = ($urandom_range(9) != 0);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((aw_src.size() + w_src.size() + req_q.size() + dat_q.size() + outst > 0
            || in_TOP_AWVALID || in_TOP_WVALID) && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_drain_in_budget"}, (k < budget), 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_bus_awvalid", out_BUS_AWVALID, 1'b0);
    chk("rst_bus_wvalid", out_BUS_WVALID, 1'b0);
    req_q.delete();
    dat_q.delete();
    aw_src.delete();
    w_src.delete();
    pend_w = 0;
    outst = 0;
    b_owed = 0;
    exp_stall = 0;
    in_TOP_AWVALID = 1'b0;
    in_TOP_WVALID = 1'b0;
    in_BUS_BVALID = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_aw(input int len);
    aw_t a;
    a.addr = $urandom;
    a.len  = LW'(len);
    aw_src.push_back(a);
  endtask

  task automatic push_w(input logic last);
    w_t w;
    w.last = last;
    w.strb = SW'($urandom);
    w.data = $urandom;
    w_src.push_back(w);
  endtask

  task automatic bus_ready(input logic awr, input logic wr);
    in_BUS_AWREADY = awr;
    in_BUS_WREADY  = wr;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time budget expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, seen, k;
    n_vec = 0; n_bad = 0; dut_aw_hs = 0; dut_w_hs = 0; dut_up_w = 0;
    b_mode = 1; rnd_mode = 0;
    reset_n = 1'b1; clk_en = 1'b1;
    in_TOP_AWADDR = '0; in_TOP_AWLEN = '0; in_TOP_AWVALID = 1'b0;
    in_TOP_WDATA = '0; in_TOP_WSTRB = '0; in_TOP_WLAST = 1'b0; in_TOP_WVALID = 1'b0;
    in_TOP_BREADY = 1'b1; in_BUS_AWREADY = 1'b1; in_BUS_WREADY = 1'b1; in_BUS_BVALID = 1'b0;
    #3;
    do_reset();
    repeat (2) step();

    // AWLEN=3: no bus AW until the WLAST beat is buffered, then AWVALID within 2 cycles
    push_aw(3);
    repeat (3) push_w(1'b0);
    seen = 0;
    repeat (8) begin step(); seen |= int'(obs_awvalid); end
    chk("s1_no_aw_before_wlast", seen, 0);
    push_w(1'b1);
    base = dut_up_w;
    k = 0;
    while (dut_up_w == base && k < 20) begin step(); k++; end
    chk("s1_wlast_accepted", (k < 20), 1'b1);
    seen = 0;
    repeat (2) begin step(); seen |= int'(obs_awvalid); end
    chk("s1_aw_within_2", seen, 1);
    drain("s1", 200);

    // Outstanding limit of 2 with B withheld, then a single B frees the third AW
    b_mode = 0;
    base = dut_aw_hs;
    repeat (3) begin push_aw(0); push_w(1'b1); end
    repeat (20) step();
    chk("s2_aw_limited", dut_aw_hs - base, 2);
    b_mode = 3;
    repeat (10) step();
    chk("s2_third_aw", dut_aw_hs - base, 3);
    b_mode = 1;
    drain("s2", 200);

    // Data FIFO fills at 4 with bus W stalled; order checked while draining
    bus_ready(1'b1, 1'b0);
    base = dut_up_w;
    repeat (4) push_w(1'b1);
    push_w(1'b0);
    push_w(1'b1);
    repeat (12) step();
    chk("s3_accepted", dut_up_w - base, 4);
    chk("s3_wready_low", obs_wready, 1'b0);
    chk("s3_no_w_before_aw", obs_wvalid, 1'b0);
    repeat (4) push_aw(0);
    push_aw(1);
    bus_ready(1'b1, 1'b1);
    drain("s3", 300);

    // Bus WLAST pop coincides with an upstream WLAST push
    bus_ready(1'b1, 1'b0);
    push_aw(0);
    push_w(1'b1);
    repeat (6) step();
    push_aw(0);
    push_w(1'b1);
    step();
    bus_ready(1'b1, 1'b1);
    step();
    chk("s4_last_cnt_before", obs_last_cnt, 1);
    step();
    chk("s4_last_cnt_after", obs_last_cnt, 1);
    drain("s4", 200);

    // Reset mid-burst with both bus valids high and 2 beats buffered
    bus_ready(1'b0, 1'b0);
    repeat (2) begin push_aw(0); push_w(1'b1); end
    repeat (6) step();
    bus_ready(1'b1, 1'b0);
    step();
    bus_ready(1'b0, 1'b0);
    step();
    chk("s5_pre_awvalid", obs_awvalid, 1'b1);
    chk("s5_pre_wvalid", obs_wvalid, 1'b1);
    do_reset();
    bus_ready(1'b1, 1'b1);
    base = dut_w_hs;
    seen = 0;
    repeat (6) begin step(); seen |= int'(obs_wvalid); end
    chk("s5_no_w_after_reset", seen, 0);
    chk("s5_no_w_hs_after_reset", dut_w_hs - base, 0);

`ifdef GMEM_WTHROTTLE_STATS_EN
    push_aw(0);
    step();
    step();
    repeat (10) step();
    step();
    chk("s6_stat_10", obs_stat, 10);
    push_w(1'b1);
    drain("s6", 200);
`endif

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      int len;
      len = $urandom_range(3);
      push_aw(len);
      for (int j = 0; j <= len; j++) push_w(j == len);
    end
    rnd_mode = 1; b_mode = 2; p_aw = 60; p_w = 70;
    drain("rand", 20000);
    rnd_mode = 0; clk_en = 1'b1; in_TOP_BREADY = 1'b1; b_mode = 1;
    bus_ready(1'b1, 1'b1);
    drain("rand_tail", 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
